// File: rtl/rv_enc_pkg.sv
// rv_enc_pkg: instruction formats, opcodes and the immediate range helper
// shared by the encoder and its packing sub-block.
package rv_enc_pkg;
    localparam int ILEN = 32;
    localparam int RW   = 5;
    localparam int FITW = 64;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [2:0] F3_ADDI    = 3'b000;
    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_LI} fmt_e;
    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_LI_HI} state_e;
    // true when v is representable as an n-bit two's-complement value
    function automatic logic fits(input logic [FITW-1:0] v, input int n);
        logic [FITW-1:0] s;
        s = FITW'($signed(v) >>> (n - 1));
        return (s == '0) || (s == '1);
    endfunction
endpackage

// File: rtl/imm_pack.sv
// imm_pack: packs one RV instruction word from a format tag, register fields
// and an immediate, flagging immediates that do not fit the format.
module imm_pack
    import rv_enc_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  fmt_e              fmt_i,
    input  logic [6:0]        op_i,
    input  logic [2:0]        f3_i,
    input  logic [6:0]        f7_i,
    input  logic [RW-1:0]     rd_i,
    input  logic [RW-1:0]     rs1_i,
    input  logic [RW-1:0]     rs2_i,
    input  logic [XLEN-1:0]   imm_i,
    output logic [ILEN-1:0]   word_o,
    output logic              err_o
);
    logic [FITW-1:0] v;
    assign v = FITW'($signed(imm_i));
    always_comb begin
        word_o = '0;
        err_o  = 1'b0;
        case (fmt_i)
            FMT_R: word_o = {f7_i, rs2_i, rs1_i, f3_i, rd_i, op_i};
            FMT_I: begin
                word_o = {imm_i[11:0], rs1_i, f3_i, rd_i, op_i};
                err_o  = !fits(v, 12);
            end
            FMT_S: begin
                word_o = {imm_i[11:5], rs2_i, rs1_i, f3_i, imm_i[4:0], op_i};
                err_o  = !fits(v, 12);
            end
            FMT_B: begin
                word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3_i, imm_i[4:1], imm_i[11], op_i};
                err_o  = !fits(v, 13) || imm_i[0];
            end
            FMT_U: begin
                word_o = {imm_i[31:12], rd_i, op_i};
                err_o  = !fits(v, 32) || (imm_i[11:0] != '0);
            end
            FMT_J: begin
                word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op_i};
                err_o  = !fits(v, 21) || imm_i[0];
            end
            default: err_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: registered valid/ready instruction encoder; expands LI into
// LUI+ADDI, reusing the single packer for the pending ADDI beat.
module instr_encoder
    import rv_enc_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter bit LI_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_fmt,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic [4:0]      in_rd,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [XLEN-1:0] in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic            out_err,
    output logic            out_last
);
    state_e state_q, state_d;
    logic [ILEN-1:0] instr_q, instr_d, pk_word;
    logic err_q, err_d, last_q, last_d;
    logic [11:0] lo_q, lo_d;
    logic [RW-1:0] rd_q, rd_d, pk_rd, pk_rs1, pk_rs2;
    logic hi_beat, accept, is_li, li_mode, li_long, li_err, li_split, pk_err;
    logic [19:0] hi20;
    fmt_e pk_fmt;
    logic [6:0] pk_op, pk_f7;
    logic [2:0] pk_f3;
    logic [XLEN-1:0] pk_imm;
    assign hi_beat  = state_q == S_LI_HI;
    assign in_ready = (state_q == S_IDLE) || (state_q == S_HOLD && out_ready);
    assign accept   = in_valid && in_ready;
    assign is_li    = in_fmt == FMT_LI;
    assign li_mode  = hi_beat || is_li;
    assign li_long  = !fits(FITW'($signed(in_imm)), 12);
    // top of the 32-bit range would round hi past 0x7FFFF
    assign li_err   = !LI_EN || !fits(FITW'($signed(in_imm)), 32) || (!in_imm[31] && &in_imm[30:11]);
    assign li_split = is_li && li_long && (in_imm[11:0] != '0);
    assign hi20     = in_imm[31:12] + 20'(in_imm[11]);
    assign pk_fmt = hi_beat ? FMT_I : !is_li ? fmt_e'(in_fmt) : li_long ? FMT_U : FMT_I;
    assign pk_op  = hi_beat ? OPC_OP_IMM : !is_li ? in_opcode : li_long ? OPC_LUI : OPC_OP_IMM;
    assign pk_f3  = li_mode ? F3_ADDI : in_funct3;
    assign pk_f7  = li_mode ? '0 : in_funct7;
    assign pk_rs2 = li_mode ? '0 : in_rs2;
    assign pk_rd  = hi_beat ? rd_q : in_rd;
    assign pk_rs1 = hi_beat ? rd_q : is_li ? '0 : in_rs1;
    assign pk_imm = hi_beat ? XLEN'($signed(lo_q))
                  : (is_li && li_long) ? XLEN'($signed({hi20, 12'h000})) : in_imm;
    imm_pack #(.XLEN(XLEN)) u_pack (
        .fmt_i(pk_fmt), .op_i(pk_op), .f3_i(pk_f3), .f7_i(pk_f7),
        .rd_i(pk_rd), .rs1_i(pk_rs1), .rs2_i(pk_rs2), .imm_i(pk_imm),
        .word_o(pk_word), .err_o(pk_err)
    );
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        err_d   = err_q;
        last_d  = last_q;
        lo_d    = lo_q;
        rd_d    = rd_q;
        if (hi_beat && out_ready) begin
            state_d = S_HOLD;
            instr_d = pk_word;
            err_d   = 1'b0;
            last_d  = 1'b1;
        end else if (accept && (pk_err || (is_li && li_err))) begin
            state_d = S_HOLD;
            instr_d = '0;
            err_d   = 1'b1;
            last_d  = 1'b1;
        end else if (accept) begin
            state_d = li_split ? S_LI_HI : S_HOLD;
            instr_d = pk_word;
            err_d   = 1'b0;
            last_d  = !li_split;
            lo_d    = in_imm[11:0];
            rd_d    = in_rd;
        end else if (state_q == S_HOLD && out_ready) begin
            state_d = S_IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            lo_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            last_q  <= last_d;
            lo_q    <= lo_d;
            rd_q    <= rd_d;
        end
    end
    assign out_valid = state_q != S_IDLE;
    assign out_instr = instr_q;
    assign out_err   = err_q;
    assign out_last  = last_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors, LI/backpressure/reset sequences and a
// randomized stream checked against an arithmetic reference model.
module tb_instr_encoder;
    import rv_enc_pkg::*;
    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, out_err, out_last;
    logic [2:0] in_fmt = '0, in_funct3 = '0;
    logic [6:0] in_opcode = '0, in_funct7 = '0;
    logic [4:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [63:0] in_imm = '0;
    logic [31:0] out_instr;
    int n_chk = 0, n_pass = 0;

    typedef struct {
        logic [2:0] fmt; logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
        logic [4:0] rd, rs1, rs2; logic [63:0] imm;
    } req_t;
    typedef struct { logic [31:0] instr; logic err; logic last; } beat_t;
    typedef struct { req_t r; beat_t b; } vec_t;
    beat_t exp_q[$];
    vec_t tbl[18];

    always #5 clk = ~clk;

    instr_encoder #(.XLEN(64), .LI_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_err(out_err), .out_last(out_last)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic see(input string nm, input logic [31:0] ins, input logic err, input logic last);
        chk({nm, ".valid"}, 64'(out_valid), 64'(1));
        chk({nm, ".instr"}, 64'(out_instr), 64'(ins));
        chk({nm, ".err"}, 64'(out_err), 64'(err));
        chk({nm, ".last"}, 64'(out_last), 64'(last));
    endtask

    function automatic req_t mk(logic [2:0] fmt, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic [63:0] imm);
        req_t r;
        r.fmt = fmt; r.op = op; r.f3 = f3; r.f7 = f7;
        r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
        return r;
    endfunction

    function automatic vec_t vv(req_t r, logic [31:0] ins, logic err);
        vec_t v;
        v.r = r; v.b.instr = ins; v.b.err = err; v.b.last = 1'b1;
        return v;
    endfunction

    task automatic drive(input req_t r);
        in_fmt = r.fmt; in_opcode = r.op; in_funct3 = r.f3; in_funct7 = r.f7;
        in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2; in_imm = r.imm;
    endtask

    // present a request until accepted; returns just after the accepting edge
    task automatic send(input req_t r);
        bit ok = 1'b0;
        drive(r);
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) chk("accept_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // reference model: plain arithmetic on the signed immediate value
    function automatic bit fitsn(longint v, int n);
        longint lim = longint'(1) << (n - 1);
        return v >= -lim && v < lim;
    endfunction

    function automatic logic [31:0] enc_i(longint imm, int rs1, int f3, int rd, int op);
        return 32'(((imm & 64'hFFF) << 20) | longint'(rs1 << 15) | longint'(f3 << 12) | longint'(rd << 7) | longint'(op));
    endfunction

    function automatic beat_t good(logic [31:0] w, logic last);
        beat_t b;
        b.instr = w; b.err = 1'b0; b.last = last;
        return b;
    endfunction

    function automatic void model(req_t r);
        longint imm = longint'(r.imm);
        longint lo, hi, w;
        int rd = int'(r.rd), rs1 = int'(r.rs1), rs2 = int'(r.rs2), f3 = int'(r.f3), op = int'(r.op);
        beat_t bad;
        bad.instr = '0; bad.err = 1'b1; bad.last = 1'b1;
        case (r.fmt)
            3'd0: exp_q.push_back(good(32'((int'(r.f7) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op), 1'b1));
            3'd1: exp_q.push_back(fitsn(imm, 12) ? good(enc_i(imm, rs1, f3, rd, op), 1'b1) : bad);
            3'd2: begin
                w = (((imm >>> 5) & 64'h7F) << 25) | longint'((rs2 << 20) | (rs1 << 15) | (f3 << 12) | op) | ((imm & 64'h1F) << 7);
                exp_q.push_back(fitsn(imm, 12) ? good(32'(w), 1'b1) : bad);
            end
            3'd3: begin
                w = (((imm >>> 12) & 1) << 31) | (((imm >>> 5) & 64'h3F) << 25) | (((imm >>> 1) & 64'hF) << 8)
                  | (((imm >>> 11) & 1) << 7) | longint'((rs2 << 20) | (rs1 << 15) | (f3 << 12) | op);
                exp_q.push_back(fitsn(imm, 13) && (imm & 1) == 0 ? good(32'(w), 1'b1) : bad);
            end
            3'd4: begin
                w = (imm & 64'hFFFFF000) | longint'((rd << 7) | op);
                exp_q.push_back(fitsn(imm, 32) && (imm & 64'hFFF) == 0 ? good(32'(w), 1'b1) : bad);
            end
            3'd5: begin
                w = (((imm >>> 20) & 1) << 31) | (((imm >>> 1) & 64'h3FF) << 21) | (((imm >>> 11) & 1) << 20)
                  | (((imm >>> 12) & 64'hFF) << 12) | longint'((rd << 7) | op);
                exp_q.push_back(fitsn(imm, 21) && (imm & 1) == 0 ? good(32'(w), 1'b1) : bad);
            end
            3'd6: begin
                if (!fitsn(imm, 32) || (imm >= 64'sh7FFFF800 && imm <= 64'sh7FFFFFFF)) exp_q.push_back(bad);
                else if (fitsn(imm, 12)) exp_q.push_back(good(enc_i(imm, 0, 0, rd, 'h13), 1'b1));
                else begin
                    lo = ((imm & 64'hFFF) ^ 64'h800) - 64'h800;
                    hi = (imm - lo) >>> 12;
                    exp_q.push_back(good(32'(((hi & 64'hFFFFF) << 12) | longint'((rd << 7) | 'h37)), lo == 0));
                    if (lo != 0) exp_q.push_back(good(enc_i(lo, rd, 0, rd, 'h13), 1'b1));
                end
            end
            default: exp_q.push_back(bad);
        endcase
    endfunction

    function automatic req_t rand_req();
        req_t r;
        longint m;
        r = mk(3'($urandom_range(0, 7)), 7'($urandom), 3'($urandom), 7'($urandom),
               5'($urandom), 5'($urandom), 5'($urandom), 64'(0));
        case ($urandom_range(0, 4))
            0: r.imm = 64'($signed(13'($urandom)));
            1: r.imm = 64'($signed(32'($urandom)));
            2: r.imm = {$urandom, $urandom};
            3: r.imm = 64'(64'sh7FFFF800 + longint'($urandom_range(0, 4095)) - 2048);
            default: begin
                m = longint'(1) << $urandom_range(10, 32);
                r.imm = 64'(($urandom_range(0, 1) != 0 ? m : -m) + longint'(int'($urandom_range(0, 2)) - 1));
            end
        endcase
        if ($urandom_range(0, 2) == 0) r.imm[11:0] = '0;
        else if ($urandom_range(0, 1) != 0) r.imm[0] = 1'b0;
        return r;
    endfunction

    initial begin
        beat_t b;
        bit acc, stall_prev;
        logic [31:0] prev_instr;
        tbl[0]  = vv(mk(FMT_I, 7'h13, 0, 0, 1, 2, 0, -64'sd1), 32'hFFF10093, 0);
        tbl[1]  = vv(mk(FMT_B, 7'h63, 0, 0, 0, 1, 2, 64'd8), 32'h00208463, 0);
        tbl[2]  = vv(mk(FMT_B, 7'h63, 0, 0, 0, 1, 2, 64'd7), 32'h0, 1);
        tbl[3]  = vv(mk(FMT_I, 7'h13, 0, 0, 1, 2, 0, 64'd2048), 32'h0, 1);
        tbl[4]  = vv(mk(FMT_LI, 7'h00, 0, 0, 3, 0, 0, 64'd5), 32'h00500193, 0);
        tbl[5]  = vv(mk(FMT_LI, 7'h00, 0, 0, 5, 0, 0, 64'h7FFFF900), 32'h0, 1);
        tbl[6]  = vv(mk(FMT_R, 7'h33, 0, 7'h20, 1, 2, 3, 64'hDEAD), 32'h403100B3, 0);
        tbl[7]  = vv(mk(FMT_S, 7'h23, 3, 0, 0, 1, 2, 64'd8), 32'h0020B423, 0);
        tbl[8]  = vv(mk(FMT_U, 7'h37, 0, 0, 1, 0, 0, 64'h12345000), 32'h123450B7, 0);
        tbl[9]  = vv(mk(FMT_U, 7'h37, 0, 0, 1, 0, 0, 64'h12345001), 32'h0, 1);
        tbl[10] = vv(mk(FMT_J, 7'h6F, 0, 0, 1, 0, 0, 64'd8), 32'h008000EF, 0);
        tbl[11] = vv(mk(FMT_J, 7'h6F, 0, 0, 1, 0, 0, 64'h100000), 32'h0, 1);
        tbl[12] = vv(mk(3'd7, 7'h13, 0, 0, 1, 2, 3, 64'd0), 32'h0, 1);
        tbl[13] = vv(mk(FMT_LI, 7'h00, 0, 0, 5, 0, 0, 64'h1000), 32'h000012B7, 0);
        tbl[14] = vv(mk(FMT_I, 7'h13, 0, 0, 1, 0, 0, 64'd2047), 32'h7FF00093, 0);
        tbl[15] = vv(mk(FMT_B, 7'h63, 0, 0, 0, 1, 2, -64'sd4096), 32'h80208063, 0);
        tbl[16] = vv(mk(FMT_LI, 7'h00, 0, 0, 5, 0, 0, 64'hFFFFFFFF80000000), 32'h800002B7, 0);
        tbl[17] = vv(mk(FMT_LI, 7'h00, 0, 0, 5, 0, 0, 64'h7FFFF800), 32'h0, 1);

        #12;
        chk("rst.valid", 64'(out_valid), 64'(0));
        chk("rst.instr", 64'(out_instr), 64'(0));
        chk("rst.err", 64'(out_err), 64'(0));
        chk("rst.last", 64'(out_last), 64'(0));
        chk("rst.in_ready", 64'(in_ready), 64'(1));
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            chk($sformatf("vec%0d.idle", i), 64'(out_valid), 64'(0));
            send(tbl[i].r);
            @(negedge clk);
            see($sformatf("vec%0d", i), tbl[i].b.instr, tbl[i].b.err, tbl[i].b.last);
            @(posedge clk); #1;
        end

        send(mk(FMT_LI, 7'h00, 0, 0, 5, 0, 0, 64'h12345FFF));
        @(negedge clk);
        see("li_lui", 32'h123462B7, 0, 0);
        chk("li_gap.in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        see("li_addi", 32'hFFF28293, 0, 1);
        @(negedge clk);
        chk("li_done.valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1;

        out_ready = 1'b0;
        send(mk(FMT_I, 7'h13, 0, 0, 1, 2, 0, -64'sd1));
        drive(mk(FMT_I, 7'h13, 0, 0, 2, 0, 0, 64'd5));
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            see($sformatf("bp%0d", k), 32'hFFF10093, 0, 1);
            chk($sformatf("bp%0d.in_ready", k), 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        #1 chk("bp_release.in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        see("bp_next", 32'h00500113, 0, 1);
        @(posedge clk); #1;

        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                drive(mk(FMT_I, 7'h13, 0, 0, 5'(k + 1), 0, 0, 64'(k + 1)));
                in_valid = 1'b1;
            end else in_valid = 1'b0;
            @(negedge clk);
            if (k > 0) see($sformatf("b2b%0d", k - 1), 32'(((k) << 20) | ((k) << 7) | 'h13), 0, 1);
            if (k < 4) chk($sformatf("b2b%0d.in_ready", k), 64'(in_ready), 64'(1));
            @(posedge clk); #1;
        end

        out_ready = 1'b0;
        send(mk(FMT_LI, 7'h00, 0, 0, 5, 0, 0, 64'h12345FFF));
        @(negedge clk);
        see("rst_li", 32'h123462B7, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_async.valid", 64'(out_valid), 64'(0));
        chk("rst_async.last", 64'(out_last), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst_no_addi%0d", k), 64'(out_valid), 64'(0));
        end
        @(posedge clk); #1;
        send(mk(FMT_I, 7'h13, 0, 0, 1, 2, 0, -64'sd1));
        @(negedge clk);
        see("post_rst", 32'hFFF10093, 0, 1);
        @(posedge clk); #1;

        stall_prev = 1'b0;
        prev_instr = '0;
        exp_q.delete();
        for (int c = 0; c < 3000; c++) begin
            req_t cur;
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                cur = rand_req();
                drive(cur);
                in_valid = 1'b1;
            end
            out_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            if (stall_prev) begin
                chk("stall.valid", 64'(out_valid), 64'(1));
                chk("stall.instr", 64'(out_instr), 64'(prev_instr));
            end
            stall_prev = out_valid && !out_ready;
            prev_instr = out_instr;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("rand.unexpected_beat", 64'(1), 64'(0));
                else begin
                    b = exp_q.pop_front();
                    chk("rand.instr", 64'(out_instr), 64'(b.instr));
                    chk("rand.err", 64'(out_err), 64'(b.err));
                    chk("rand.last", 64'(out_last), 64'(b.last));
                end
            end
            acc = in_valid && in_ready;
            if (acc) model(mk(in_fmt, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm));
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) begin
                if (exp_q.size() == 0) chk("drain.unexpected_beat", 64'(1), 64'(0));
                else begin
                    b = exp_q.pop_front();
                    chk("drain.instr", 64'(out_instr), 64'(b.instr));
                    chk("drain.last", 64'(out_last), 64'(b.last));
                end
            end
            @(posedge clk); #1;
        end
        chk("drain.empty", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
